cordic_range_ctrl: RTL
======================

Name: cordic_range_ctrl

Overview:
- Front/back-end controller wrapped around the iterative CORDIC rotation core.
- Accepts angles in [-PI, PI] over a valid/ready stream and folds them into [-PI/2, PI/2], the core's convergence range.
- Sequences the core's start/done handshake, then applies quadrant sign correction to the core's x/y.
- Presents cos/sin results on a valid/ready output stream.

Parameters:
- NUM_WIDTH, 24, width of all angle/result words; signed Q4.20 two's complement.
- TIMEOUT, 64, maximum cycles spent waiting on the core before aborting.
- TO_WIDTH, 7, width of the timeout counter; must satisfy 2^TO_WIDTH > TIMEOUT.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  input angle valid
- in_ready  out  1  controller can accept an angle
- in_angle  in  NUM_WIDTH  angle, Q4.20 radians
- core_start  out  1  drives the core's data_loaded
- core_angle  out  NUM_WIDTH  drives the core's angle
- core_x  in  NUM_WIDTH  core x (cos) result
- core_y  in  NUM_WIDTH  core y (sin) result
- core_done  in  1  core's data_computed
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_cos  out  NUM_WIDTH  cos, Q4.20
- out_sin  out  NUM_WIDTH  sin, Q4.20
- out_err  out  1  result invalid (range or timeout)

Behaviour:
- Reset: rst asynchronous, active-high; clock clk.
  - State = IDLE.
  - in_ready=1, core_start=0, core_angle=0, out_valid=0, out_cos=0, out_sin=0, out_err=0, negate flag=0, timeout counter=0.
- Constants (Q4.20): PI = 0x3243F6, HALF_PI = 0x1921FB.
- Range fold, applied on the accept edge and registered:
  - angle > HALF_PI: z = angle - PI, neg = 1.
  - angle < -HALF_PI: z = angle + PI, neg = 1.
  - otherwise: z = angle, neg = 0.
  - Comparisons and sums are signed; sums are NUM_WIDTH+1 bits internally, truncated to NUM_WIDTH.
  - |angle| > PI sets a range_err flag; processing still continues.
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch core_angle=z, neg and range_err, then go to START.
  - START: core_start=1 for exactly one cycle with core_angle stable, then go to WAIT_LO. The core detects a rising edge, so core_start must be low in IDLE and in every other state.
  - WAIT_LO: wait until core_done==0 is sampled (core has begun), then go to WAIT_HI.
  - WAIT_HI: wait until core_done==1 is sampled, then latch results and go to OUT:
    - out_cos = neg ? -core_x : core_x
    - out_sin = neg ? -core_y : core_y
    - out_err = range_err
  - OUT: out_valid=1; outputs are held stable until out_ready. On the out_valid && out_ready cycle, go to IDLE.
- Timeout:
  - The counter clears on entry to START and increments each cycle in WAIT_LO/WAIT_HI.
  - On reaching TIMEOUT: go to OUT with out_cos=0, out_sin=0, out_err=1.
- Latency:
  - Accept to out_valid = 3 + core iteration time; the 19-iteration core gives ~23 cycles.
  - No second angle is accepted until the previous result is taken; throughput is one result per transaction.
- Boundaries:
  - angle exactly ±HALF_PI: not folded.
  - angle exactly +PI: folds to 0, neg=1.
  - angle exactly -PI: folds to 0, neg=1.
  - Negating the most negative value wraps (two's complement); this cannot occur for legal core outputs.
- Reset mid-operation: returns to IDLE immediately. Any pending result is discarded; out_valid is not asserted afterward. The core is reset by the same rst.
- Any in_valid while in_ready=0 is ignored; upstream must hold it until the handshake.

Decomposition:
- Shared package cordic_pkg holds:
  - NUM_WIDTH default
  - PI, HALF_PI, CORDIC_RATIO constants
  - the state enum {IDLE, START, WAIT_LO, WAIT_HI, OUT}
- One natural sub-module: cordic_range_fold.
  - Combinational: angle in; z, neg, range_err out.
  - Reusable by a future pipelined core.
- Top-level integration instantiates cordic_range_ctrl beside the core; the controller does not instantiate the core.

Test Plan:
- in_angle=0, out_ready=1 → out_cos≈0x100000, out_sin≈0 (±16 LSB), out_err=0; core_start high exactly 1 cycle.
- in_angle=0x3243F6 (PI) → core_angle=0, out_cos≈0xF00000 (-1.0), out_sin≈0, out_err=0.
- in_angle=-0x25B2F9 (-3PI/4) → core_angle≈+PI/4, out_cos≈out_sin≈-0x0B504F (±16 LSB).
- in_angle=0x1921FB (HALF_PI) → no fold (core_angle=0x1921FB), out_cos≈0, out_sin≈0x100000.
- out_ready held 0 for 10 cycles after out_valid → outputs stable, in_ready=0, second in_valid ignored; the result transfers on the first out_ready=1 cycle.
- Core stub holding core_done=1 → after TIMEOUT cycles out_valid=1, out_err=1, out_cos=out_sin=0.
- rst pulsed during WAIT_HI → next cycle all outputs at reset values; a new angle completes normally afterward.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC range controller and its helpers.
//   NUM_WIDTH_DEF : default angle/result word width (signed Q4.20)
//   PI, HALF_PI   : Q4.20 constants used by the range fold
//   CORDIC_RATIO  : core gain compensation constant (1/K), Q4.20
//   state_t       : controller sequencing states
package cordic_pkg;

  localparam int NUM_WIDTH_DEF = 24;

  // Q4.20 fixed-point constants; kept as int so they resize to any word width.
  localparam int PI           = 32'h0032_43F6;
  localparam int HALF_PI      = 32'h0019_21FB;
  localparam int CORDIC_RATIO = 32'h0009_B74E;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_LO,
    WAIT_HI,
    OUT
  } state_t;

endpackage

// File: rtl/cordic_range_ctrl_if.sv
// Handshake/bus bundle between the range controller and its neighbours.
//   in_*   : upstream angle stream (valid/ready)
//   core_* : start/done handshake and data towards the iterative core
//   out_*  : downstream cos/sin result stream (valid/ready)
// master = controller view, slave = environment (upstream, core, downstream).
interface cordic_range_ctrl_if
  import cordic_pkg::*;
#(
  parameter int NUM_WIDTH = NUM_WIDTH_DEF
);

  logic                 in_valid;
  logic                 in_ready;
  logic [NUM_WIDTH-1:0] in_angle;

  logic                 core_start;
  logic [NUM_WIDTH-1:0] core_angle;
  logic [NUM_WIDTH-1:0] core_x;
  logic [NUM_WIDTH-1:0] core_y;
  logic                 core_done;

  logic                 out_valid;
  logic                 out_ready;
  logic [NUM_WIDTH-1:0] out_cos;
  logic [NUM_WIDTH-1:0] out_sin;
  logic                 out_err;

  modport master (
    input  in_valid, in_angle, core_x, core_y, core_done, out_ready,
    output in_ready, core_start, core_angle, out_valid, out_cos, out_sin, out_err
  );

  modport slave (
    output in_valid, in_angle, core_x, core_y, core_done, out_ready,
    input  in_ready, core_start, core_angle, out_valid, out_cos, out_sin, out_err
  );

endinterface

// File: rtl/cordic_range_fold.sv
// Combinational quadrant fold of a Q4.20 angle in [-PI, PI] into the core's
// convergence range [-PI/2, PI/2].
//   angle     : input angle, signed Q4.20 radians
//   z         : folded angle handed to the core
//   neg       : result of the core must be negated (angle was shifted by PI)
//   range_err : |angle| > PI; the fold still produces a value
module cordic_range_fold
  import cordic_pkg::*;
#(
  parameter int NUM_WIDTH = NUM_WIDTH_DEF
) (
  input  logic signed [NUM_WIDTH-1:0] angle,
  output logic signed [NUM_WIDTH-1:0] z,
  output logic                        neg,
  output logic                        range_err
);

  // One extra bit so angle +/- PI cannot overflow before truncation.
  localparam logic signed [NUM_WIDTH:0] PI_X       = (NUM_WIDTH+1)'(PI);
  localparam logic signed [NUM_WIDTH:0] NEG_PI_X   = -PI_X;
  localparam logic signed [NUM_WIDTH:0] HALF_X     = (NUM_WIDTH+1)'(HALF_PI);
  localparam logic signed [NUM_WIDTH:0] NEG_HALF_X = -HALF_X;

  logic signed [NUM_WIDTH:0] angle_x;
  logic signed [NUM_WIDTH:0] sum_x;

  always_comb begin
    angle_x = {angle[NUM_WIDTH-1], angle};
    sum_x   = angle_x;
    neg     = 1'b0;
    // Exactly +/-HALF_PI stays unfolded; strict compares keep it that way.
    if (angle_x > HALF_X) begin
      sum_x = angle_x - PI_X;
      neg   = 1'b1;
    end else if (angle_x < NEG_HALF_X) begin
      sum_x = angle_x + PI_X;
      neg   = 1'b1;
    end
    z         = sum_x[NUM_WIDTH-1:0];
    range_err = (angle_x > PI_X) || (angle_x < NEG_PI_X);
  end

endmodule

// File: rtl/cordic_range_ctrl.sv
// Front/back-end controller around the iterative CORDIC rotation core.
// Accepts an angle, folds it into the core's range, pulses the core's start,
// waits for the core's done low->high sequence (with timeout), applies the
// quadrant sign correction and presents cos/sin on a valid/ready stream.
//   clk : clock
//   rst : asynchronous active-high reset (shared with the core)
//   bus : cordic_range_ctrl_if.master (in_*, core_*, out_* signals)
// Parameters: NUM_WIDTH word width, TIMEOUT max wait cycles on the core,
// TO_WIDTH timeout counter width (2**TO_WIDTH > TIMEOUT).
module cordic_range_ctrl
  import cordic_pkg::*;
#(
  parameter int NUM_WIDTH = NUM_WIDTH_DEF,
  parameter int TIMEOUT   = 64,
  parameter int TO_WIDTH  = 7
) (
  input  logic                clk,
  input  logic                rst,
  cordic_range_ctrl_if.master bus
);

  // Counter value seen on the TIMEOUT-th waiting cycle.
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT - 1);

  state_t                      state_reg;
  logic                        neg_reg;
  logic                        range_err_reg;
  logic [TO_WIDTH-1:0]         to_cnt_reg;

  logic signed [NUM_WIDTH-1:0] fold_z;
  logic                        fold_neg;
  logic                        fold_err;

  cordic_range_fold #(
    .NUM_WIDTH(NUM_WIDTH)
  ) u_fold (
    .angle     ($signed(bus.in_angle)),
    .z         (fold_z),
    .neg       (fold_neg),
    .range_err (fold_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      neg_reg        <= 1'b0;
      range_err_reg  <= 1'b0;
      to_cnt_reg     <= '0;
      bus.in_ready   <= 1'b1;
      bus.core_start <= 1'b0;
      bus.core_angle <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_cos    <= '0;
      bus.out_sin    <= '0;
      bus.out_err    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            bus.core_angle <= fold_z;
            neg_reg        <= fold_neg;
            range_err_reg  <= fold_err;
            bus.in_ready   <= 1'b0;
            // Registered so core_start is high only while in START.
            bus.core_start <= 1'b1;
            to_cnt_reg     <= '0;
            state_reg      <= START;
          end
        end

        START: begin
          bus.core_start <= 1'b0;
          state_reg      <= WAIT_LO;
        end

        WAIT_LO, WAIT_HI: begin
          to_cnt_reg <= to_cnt_reg + TO_WIDTH'(1);
          if (state_reg == WAIT_HI && bus.core_done) begin
            bus.out_cos   <= neg_reg ? -bus.core_x : bus.core_x;
            bus.out_sin   <= neg_reg ? -bus.core_y : bus.core_y;
            bus.out_err   <= range_err_reg;
            bus.out_valid <= 1'b1;
            state_reg     <= OUT;
          end else if (to_cnt_reg == TO_LAST) begin
            // Core never answered: report an error result instead of hanging.
            bus.out_cos   <= '0;
            bus.out_sin   <= '0;
            bus.out_err   <= 1'b1;
            bus.out_valid <= 1'b1;
            state_reg     <= OUT;
          end else if (state_reg == WAIT_LO && !bus.core_done) begin
            // Done low means the core has taken the start and is iterating.
            state_reg <= WAIT_HI;
          end
        end

        OUT: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state_reg     <= IDLE;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
